// File: rtl/lcd_axi_pkg.sv
// Shared types and constants for the lcd_control AXI4-Lite write sequencer.
package lcd_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2,
    ST_WAIT = 2'd3
  } seq_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [11:0] REG_CONTROL    = 12'h000;
  localparam logic [11:0] REG_PIXEL_DATA = 12'h010;

  // Word-aligned target address; the add wraps at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [11:0] off);
    return base + {20'd0, off & 12'hffc};
  endfunction

endpackage

// File: rtl/lcd_axi_sequencer.sv
// AXI4-Lite single-beat write initiator: one command in, one write out,
// response check, then a programmable hold-off before the next command.
module lcd_axi_sequencer
  import lcd_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4020_0000,
  parameter int          WAIT_W    = 32,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [11:0]       cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [3:0]        cmd_strb,
  input  logic [WAIT_W-1:0] cmd_wait,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [31:0]       M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [31:0]       M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  output logic              M_AXI_RREADY
);

  localparam int                TOUT_W    = $clog2(TIMEOUT + 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);

  seq_state_e        state_r, state_next_s;
  logic [31:0]       awaddr_r, wdata_r;
  logic [3:0]        wstrb_r;
  logic [WAIT_W-1:0] wait_lat_r, wait_cnt_r;
  logic [TOUT_W-1:0] tout_cnt_r;
  logic              awvalid_r, wvalid_r, bready_r, busy_r, done_r, err_r;
  logic [1:0]        err_code_r;
  logic              cmd_ready_s, accept_s, xfer_done_s, tout_hit_s, wait_last_s;
  logic              finish_s, bresp_err_s, tout_err_s;

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) state_r <= ST_IDLE;
    else                state_r <= state_next_s;
  end

  // Next-state logic; a channel whose valid is already low has handshaken.
  always_comb begin
    xfer_done_s  = (!awvalid_r || M_AXI_AWREADY) && (!wvalid_r || M_AXI_WREADY);
    tout_hit_s   = (tout_cnt_r == TOUT_LAST);
    wait_last_s  = (wait_cnt_r <= WAIT_W'(1));
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_next_s = ST_XFER;
        else           state_next_s = ST_IDLE;
      end
      ST_XFER: begin
        if (xfer_done_s) state_next_s = ST_RESP;
        else             state_next_s = ST_XFER;
      end
      ST_RESP: begin
        if (M_AXI_BVALID)    state_next_s = (wait_lat_r == WAIT_W'(0)) ? ST_IDLE : ST_WAIT;
        else if (tout_hit_s) state_next_s = ST_IDLE;
        else                 state_next_s = ST_RESP;
      end
      ST_WAIT: begin
        if (wait_last_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output/event decode from the current state.
  always_comb begin
    cmd_ready_s = (state_r == ST_IDLE);
    accept_s    = cmd_valid && cmd_ready_s;
    bresp_err_s = (state_r == ST_RESP) && M_AXI_BVALID && (M_AXI_BRESP != RESP_OKAY);
    tout_err_s  = (state_r == ST_RESP) && !M_AXI_BVALID && tout_hit_s;
    finish_s    = 1'b0;
    case (state_r)
      ST_RESP: finish_s = M_AXI_BVALID ? (wait_lat_r == WAIT_W'(0)) : tout_hit_s;
      ST_WAIT: finish_s = wait_last_s;
      default: finish_s = 1'b0;
    endcase
  end

  // Command latch, AXI valids, counters and status flags.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      awaddr_r   <= 32'd0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
      wait_lat_r <= '0;
      wait_cnt_r <= '0;
      tout_cnt_r <= '0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
    end else begin
      done_r   <= finish_s;
      busy_r   <= (state_next_s != ST_IDLE);
      bready_r <= (state_next_s == ST_RESP);
      if (accept_s) begin
        awaddr_r   <= word_addr(BASE_ADDR, cmd_addr);
        wdata_r    <= cmd_data;
        wstrb_r    <= cmd_strb;
        wait_lat_r <= cmd_wait;
        awvalid_r  <= 1'b1;
        wvalid_r   <= 1'b1;
      end else begin
        if (M_AXI_AWREADY) awvalid_r <= 1'b0;
        if (M_AXI_WREADY)  wvalid_r  <= 1'b0;
      end
      if ((state_r == ST_RESP) && M_AXI_BVALID) wait_cnt_r <= wait_lat_r;
      else if (state_r == ST_WAIT)              wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
      if ((state_r == ST_RESP) && !M_AXI_BVALID) tout_cnt_r <= tout_cnt_r + TOUT_W'(1);
      else                                       tout_cnt_r <= '0;
      if (bresp_err_s) begin
        err_r      <= 1'b1;
        err_code_r <= M_AXI_BRESP;
      end else if (tout_err_s) begin
        err_r      <= 1'b1;
        err_code_r <= ERR_TIMEOUT;
      end
    end
  end

  assign cmd_ready     = cmd_ready_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign err_code      = err_code_r;
  assign M_AXI_AWADDR  = awaddr_r;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = wstrb_r;
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_BREADY  = bready_r;
  assign M_AXI_ARADDR  = 32'd0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b1;

endmodule

// File: tb/tb_lcd_axi_sequencer.sv
// Scoreboard bench: expectations queued at command accept, checked as the
// AXI slave model sees handshakes and as done pulses arrive.
module tb_lcd_axi_sequencer;
  import lcd_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h4020_0000;
  localparam int          TOUT = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [11:0] cmd_addr = 12'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [3:0]  cmd_strb = 4'd0;
  logic [31:0] cmd_wait = 32'd0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;

  int total = 0, bad = 0, cyc = 0, done_cnt = 0, b_cnt = 0, resp_start = 0;
  int aw_delay = 0, w_delay = 0, aw_cnt, w_cnt, base, b_before, k;
  logic b_never = 1'b0, overlap = 1'b0;
  logic [1:0] bresp_sel = 2'b00;
  logic p_awv, p_awhs, p_wv, p_whs, p_bready;
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];
  int exp_wait_q[$];
  int exp_done_q[$];

  always #5 clk = ~clk;

  lcd_axi_sequencer dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_wait(cmd_wait),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_RREADY(rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Slave model and monitor: readies are driven and handshakes logged at negedge.
  initial begin
    aw_cnt = 0; w_cnt = 0;
    p_awv = 1'b0; p_awhs = 1'b0; p_wv = 1'b0; p_whs = 1'b0; p_bready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0;
        p_awv = 1'b0; p_awhs = 1'b0; p_wv = 1'b0; p_whs = 1'b0; p_bready = 1'b0;
      end else begin
        if (p_awhs)     check_eq("aw_drop", 64'(awvalid), 64'(0));
        else if (p_awv) check_eq("aw_hold", 64'(awvalid), 64'(1));
        if (p_whs)      check_eq("w_drop", 64'(wvalid), 64'(0));
        else if (p_wv)  check_eq("w_hold", 64'(wvalid), 64'(1));
        if (cmd_ready && busy) overlap = 1'b1;
        if (bready && !p_bready) resp_start = cyc;
        awready = awvalid && (aw_cnt >= aw_delay);
        aw_cnt  = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_delay);
        w_cnt   = wvalid ? w_cnt + 1 : 0;
        bvalid  = bready && !b_never;
        bresp   = bresp_sel;
        if (awvalid && awready) begin
          if (exp_aw_q.size() > 0) check_eq("awaddr", 64'(awaddr), 64'(exp_aw_q.pop_front()));
          else                     check_eq("aw_unexp", 64'(1), 64'(0));
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() > 0) check_eq("wstrb_wdata", 64'({wstrb, wdata}), 64'(exp_w_q.pop_front()));
          else                    check_eq("w_unexp", 64'(1), 64'(0));
        end
        if (bvalid && bready) begin
          b_cnt++;
          if (exp_wait_q.size() > 0) exp_done_q.push_back(cyc + exp_wait_q.pop_front() + 1);
          else                       check_eq("b_unexp", 64'(1), 64'(0));
        end
        if (done) begin
          done_cnt++;
          if (exp_done_q.size() > 0)      check_eq("done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
          else if (exp_wait_q.size() > 0) begin
            void'(exp_wait_q.pop_front());
            check_eq("timeout_cycles", 64'(cyc - resp_start), 64'(TOUT));
          end else                        check_eq("done_unexp", 64'(1), 64'(0));
        end
        p_awv = awvalid; p_awhs = awvalid && awready;
        p_wv = wvalid;   p_whs = wvalid && wready;
        p_bready = bready;
      end
    end
  end

  task automatic send_cmd(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int w);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_wait = 32'(w);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_accept", 64'(0), 64'(1));
      cmd_valid = 1'b0;
    end else begin
      exp_aw_q.push_back(BASE + {20'd0, a[11:2], 2'b00});
      exp_w_q.push_back({s, d});
      exp_wait_q.push_back(w);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) check_eq("done_wait", 64'(done_cnt), 64'(target));
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check_eq("rst_busy_done", 64'({busy, done}), 64'(0));
    check_eq("rst_err", 64'({err, err_code}), 64'(0));
    check_eq("rst_valids", 64'({awvalid, wvalid, bready}), 64'(0));
    check_eq("rst_awaddr", 64'(awaddr), 64'(0));
    check_eq("rst_wdata_wstrb", 64'({wstrb, wdata}), 64'(0));
    check_eq("read_tieoff", 64'({araddr, arvalid, rready}), 64'({32'd0, 1'b0, 1'b1}));
    rstn = 1'b1;

    base = done_cnt;
    send_cmd(REG_CONTROL, 32'h0000_001d, 4'hf, 50000);
    wait_done(base + 1, 51000);
    check_eq("long_wait_err", 64'(err), 64'(0));

    base = done_cnt;
    send_cmd(REG_PIXEL_DATA, 32'h1fff_0000, 4'hf, 0);
    send_cmd(REG_PIXEL_DATA, 32'h1fff_0000, 4'hf, 0);
    wait_done(base + 2, 100);

    base = done_cnt; b_before = b_cnt;
    aw_delay = 3; w_delay = 0;
    send_cmd(12'hffe, 32'h1234_5678, 4'h3, 0);
    wait_done(base + 1, 100);
    aw_delay = 0; w_delay = 3;
    send_cmd(12'h008, 32'ha5a5_5a5a, 4'hc, 2);
    wait_done(base + 2, 100);
    aw_delay = 2; w_delay = 2;
    send_cmd(12'h00c, 32'h0bad_cafe, 4'h5, 1);
    wait_done(base + 3, 100);
    aw_delay = 0; w_delay = 0;
    check_eq("b_per_cmd", 64'(b_cnt - b_before), 64'(3));

    base = done_cnt;
    bresp_sel = RESP_SLVERR;
    send_cmd(REG_CONTROL, 32'h0000_0003, 4'hf, 0);
    wait_done(base + 1, 100);
    check_eq("slverr_err", 64'({err, err_code}), 64'({1'b1, 2'b10}));
    bresp_sel = RESP_OKAY;
    send_cmd(REG_PIXEL_DATA, 32'h0000_ffff, 4'hf, 4);
    wait_done(base + 2, 100);
    check_eq("err_sticky", 64'({err, err_code}), 64'({1'b1, 2'b10}));

    base = done_cnt;
    b_never = 1'b1;
    send_cmd(REG_CONTROL, 32'h0000_0007, 4'hf, 0);
    wait_done(base + 1, TOUT + 100);
    b_never = 1'b0;
    check_eq("timeout_err", 64'({err, err_code}), 64'({1'b1, 2'b11}));
    check_eq("timeout_idle", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));

    aw_delay = 10;
    send_cmd(REG_PIXEL_DATA, 32'hdead_beef, 4'hf, 3);
    k = 0;
    while (!awvalid && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("xfer_awvalid", 64'(awvalid), 64'(1));
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_valids", 64'({awvalid, wvalid, bready}), 64'(0));
    check_eq("midrst_idle", 64'({cmd_ready, busy, err}), 64'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    #1;
    rstn = 1'b1;
    exp_aw_q.delete(); exp_w_q.delete(); exp_wait_q.delete(); exp_done_q.delete();
    aw_delay = 0;
    base = done_cnt;
    send_cmd(REG_CONTROL, 32'h0000_0001, 4'h1, 5);
    wait_done(base + 1, 100);
    check_eq("post_rst_err", 64'({err, err_code}), 64'(0));

    repeat (3) @(negedge clk);
    check_eq("b_total", 64'(b_cnt), 64'(9));
    check_eq("ready_while_busy", 64'(overlap), 64'(0));
    check_eq("sb_empty", 64'(exp_aw_q.size() + exp_w_q.size() + exp_wait_q.size() + exp_done_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
